// File: rtl/fifo_ctrl_if.sv
// Handshake bundle between a FIFO client, the pointer/flag controller and the 8x12 memory.
// The slave modport is the controller's view; master is the client/memory side.
interface fifo_ctrl_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned PTR_W  = 3
) ();

  // Client request side
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;

  // Memory side
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] data;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              write;
  logic              read;

  // Dequeue result and status
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic [PTR_W:0]    count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              overflow;
  logic              underflow;

  modport slave (
    input  push,
    input  push_data,
    input  pop,
    input  q,
    output data,
    output wr_ptr,
    output rd_ptr,
    output write,
    output read,
    output pop_data,
    output pop_valid,
    output count,
    output full,
    output empty,
    output almost_full,
    output almost_empty,
    output overflow,
    output underflow
  );

  modport master (
    output push,
    output push_data,
    output pop,
    output q,
    input  data,
    input  wr_ptr,
    input  rd_ptr,
    input  write,
    input  read,
    input  pop_data,
    input  pop_valid,
    input  count,
    input  full,
    input  empty,
    input  almost_full,
    input  almost_empty,
    input  overflow,
    input  underflow
  );

endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller turning a dual-pointer memory into a synchronous FIFO.
// Define FIFO_ALMOST_FLAGS_EN to build the almost_full/almost_empty threshold flags.
module fifo_ctrl #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned PTR_W     = 3,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 2
) (
  input logic         clk,
  input logic         reset,
  fifo_ctrl_if.slave  bus
);

  localparam logic [PTR_W:0] Depth = {1'b1, {PTR_W{1'b0}}};

  // Thresholds above the depth would leave a flag stuck.
  if (AF_THRESH > (1 << PTR_W) || AE_THRESH > (1 << PTR_W)) begin : gen_thresh_check
    $error("fifo_ctrl: almost-flag threshold exceeds FIFO depth");
  end

  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rp;
  logic              pend;

  logic [DATA_W-1:0] data_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic              write_q;
  logic              read_q;
  logic [DATA_W-1:0] pop_data_q;
  logic              pop_valid_q;
  logic [PTR_W:0]    count_q;
  logic              full_q;
  logic              empty_q;
  logic              overflow_q;
  logic              underflow_q;

  logic              push_ok;
  logic              pop_ok;
  logic [PTR_W:0]    count_d;

  // Flags are registered, so acceptance only needs the current full/empty state; a push
  // while full is refused even with a pop, so the memory never sees a same-address access.
  always_comb begin
    push_ok = bus.push & ~full_q;
    pop_ok  = bus.pop & ~empty_q;
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp          <= '0;
      rp          <= '0;
      pend        <= 1'b0;
      data_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      write_q     <= push_ok;
      read_q      <= pop_ok;
      overflow_q  <= bus.push & ~push_ok;
      underflow_q <= bus.pop & ~pop_ok;

      if (push_ok) begin
        data_q   <= bus.push_data;
        wr_ptr_q <= wp;
        wp       <= wp + 1'b1;
      end

      if (pop_ok) begin
        rd_ptr_q <= rp;
        rp       <= rp + 1'b1;
      end

      // Memory returns q one cycle after read; pend marks that q is the popped word.
      pend        <= read_q;
      pop_valid_q <= pend;
      if (pend) begin
        pop_data_q <= bus.q;
      end

      count_q <= count_d;
      full_q  <= (count_d == Depth);
      empty_q <= (count_d == '0);
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam logic [PTR_W:0] AfLevel = (PTR_W+1)'(AF_THRESH);
  localparam logic [PTR_W:0] AeLevel = (PTR_W+1)'(AE_THRESH);

  logic almost_full_q;
  logic almost_empty_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (count_d >= AfLevel);
      almost_empty_q <= (count_d <= AeLevel);
    end
  end

  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
`else
  assign bus.almost_full  = 1'b0;
  assign bus.almost_empty = 1'b0;
`endif

  assign bus.data      = data_q;
  assign bus.wr_ptr    = wr_ptr_q;
  assign bus.rd_ptr    = rd_ptr_q;
  assign bus.write     = write_q;
  assign bus.read      = read_q;
  assign bus.pop_data  = pop_data_q;
  assign bus.pop_valid = pop_valid_q;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule
